// File: rtl/store_queue.sv
// In-order store queue: holds LSQ entries until their instruction retires, then issues
// committed entries in program order. Optional output register: STORE_QUEUE_OUTPUT_REG_EN.
package store_queue_pkg;
  typedef logic [3:0] id_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sq_entry_t;
endpackage

module store_queue
  import store_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  sq_entry_t push_entry_i,
  input  id_t       push_id_i,
  output logic      full_o,
  input  logic      retire_valid_i,
  input  id_t       retire_id_i,
  input  logic      flush_i,
  output logic      mem_valid_o,
  output sq_entry_t mem_entry_o,
  input  logic      mem_ready_i,
  output logic      sq_empty_o,
  output logic      no_commited_ops_pending_o
);
  localparam int PW = $clog2(DEPTH);
  typedef logic [PW:0] ptr_t;

  logic [DEPTH-1:0] valid_q, valid_d, committed_q, committed_d;
  id_t              id_q    [DEPTH];
  sq_entry_t        entry_q [DEPTH];
  ptr_t             head_q, head_d, tail_q, tail_d, count_d, n_commit;
  logic             full_q, push_ok, head_ready, pop;
  logic [PW-1:0]    head_idx, tail_idx;

  assign head_idx   = head_q[PW-1:0];
  assign tail_idx   = tail_q[PW-1:0];
  assign push_ok    = push_i && !full_q && !flush_i;
  assign head_ready = valid_q[head_idx] && committed_q[head_idx];

`ifdef STORE_QUEUE_OUTPUT_REG_EN
  logic      out_valid_q;
  sq_entry_t out_entry_q;
  assign pop = head_ready && (!out_valid_q || mem_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i)            out_valid_q <= 1'b0;
    else if (pop)         out_valid_q <= 1'b1;
    else if (mem_ready_i) out_valid_q <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (pop) out_entry_q <= entry_q[head_idx];
  end

  assign mem_valid_o               = out_valid_q;
  assign mem_entry_o               = out_entry_q;
  assign sq_empty_o                = (tail_q == head_q) && !out_valid_q;
  assign no_commited_ops_pending_o = !(|(valid_q & committed_q)) && !out_valid_q;
`else
  assign pop                       = head_ready && mem_ready_i;
  assign mem_valid_o               = head_ready;
  assign mem_entry_o               = entry_q[head_idx];
  assign sq_empty_o                = (tail_q == head_q);
  assign no_commited_ops_pending_o = !(|(valid_q & committed_q));
`endif

  assign full_o = full_q;

  // Order matters: retire, then pop, then flush truncation (which keeps the committed prefix).
  always_comb begin
    valid_d     = valid_q;
    committed_d = committed_q;
    n_commit    = '0;
    tail_d      = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && retire_valid_i && id_q[i] == retire_id_i) committed_d[i] = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_commit = n_commit + ptr_t'(valid_q[i] & committed_d[i]);
    end
    if (pop) begin
      valid_d[head_idx]     = 1'b0;
      committed_d[head_idx] = 1'b0;
    end
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!committed_d[i]) valid_d[i] = 1'b0;
      end
      tail_d = head_q + n_commit;
    end else if (push_ok) begin
      valid_d[tail_idx]     = 1'b1;
      committed_d[tail_idx] = retire_valid_i && (retire_id_i == push_id_i);
      tail_d                = tail_q + ptr_t'(1);
    end
    head_d  = head_q + ptr_t'(pop);
    count_d = tail_d - head_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      committed_q <= '0;
      full_q      <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      committed_q <= committed_d;
      full_q      <= (count_d == ptr_t'(DEPTH));
    end
  end

  // NOTE: payload and ID storage is not reset; valid_q gates every use of it.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      id_q[tail_idx]    <= push_id_i;
      entry_q[tail_idx] <= push_entry_i;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
endmodule

// File: doc/store_queue.md
# store_queue

In-order store queue sitting directly downstream of the load-store queue, which feeds it `sq_entry_t` records for every destructive memory access (stores, AMO SC/RMW, peripheral loads). It holds each entry until its instruction ID retires, then issues committed entries in program order to the data-memory subunits through a valid/ready handshake. It also drives the `sq_empty` and `no_commited_ops_pending` fields of `load_store_status_t`, and discards uncommitted entries on a memory-queue flush.

## Interface
- `DEPTH`, 4, number of entries; power of two, 2..16
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `push`  in  1  enqueue request from LSQ
- `push_entry`  in  `sq_entry_t`  entry payload
- `push_id`  in  `id_t`  instruction ID of the entry
- `full`  out  1  no free slot; registered
- `retire_valid`  in  1  one instruction retiring this cycle
- `retire_id`  in  `id_t`  ID of the retiring instruction
- `flush`  in  1  `gc_outputs_t.memq_flush`; drop all uncommitted entries
- `mem_valid`  out  1  committed head entry is available
- `mem_entry`  out  `sq_entry_t`  head entry payload
- `mem_ready`  in  1  subunit accepts `mem_entry`
- `sq_empty`  out  1  no entries held
- `no_commited_ops_pending`  out  1  no committed entry awaiting issue

## Operation
- Circular buffer: head and tail pointers of `$clog2(DEPTH)` bits plus one wrap bit each. Count = tail − head, modulo 2·DEPTH.
- Per-slot state: `valid`, `committed`, `id`, payload.
- Push (`push && !full && !flush`): write at tail, set `valid`, and advance tail. `committed` = `retire_valid && retire_id == push_id`.
- Pushing while `full` is illegal and is covered by an assertion; the entry is not written.
- Retire: every valid, uncommitted slot whose `id` == `retire_id` sets `committed`. If no slot matches, the retire is ignored.
- Commits arrive in program order, so committed slots always form a contiguous prefix from head.
- Pop: `mem_valid && mem_ready` clears the head slot and advances head.
- Flush: retire is evaluated first in the same cycle. Tail is then moved to the first uncommitted slot, or to head if none are committed. Dropped slots have `valid` cleared. A push in the same cycle as the flush is discarded. A pop in the same cycle still completes.
- Outputs:
  - `full` = count == DEPTH.
  - `sq_empty` = count == 0.
  - `no_commited_ops_pending` = no slot has both `valid` and `committed` set.
- Reset: head = tail = 0, all `valid`/`committed` = 0, so `full` = 0, `mem_valid` = 0, `sq_empty` = 1, `no_commited_ops_pending` = 1.

## Timing
- Push in cycle N: entry is visible, and counted in `full`/`sq_empty`, from N+1.
- Commit-to-issue latency: retire in cycle N makes a head entry raise `mem_valid` in N+1. A non-head entry raises it the cycle after the preceding entry pops.
- `mem_valid` and `mem_entry` hold stable until `mem_ready` is sampled high.
- Throughput: one pop per cycle. Push and pop may occur in the same cycle, and count is then unchanged.
- When the queue is full, a pop in cycle N frees a slot; `full` deasserts in N+1. No same-cycle push-through.
- Wrap: pointers wrap at DEPTH with the wrap bit toggling. Full and empty are distinguished by the wrap bits.

## Configuration
- `STORE_QUEUE_OUTPUT_REG_EN` defined:
  - A one-entry output register sits between head and `mem_*`.
  - Head pops into the register when the register is empty or is being drained.
  - Commit-to-issue latency becomes 2 cycles; a full throughput of one per cycle is kept.
  - Registered entries are always committed, so flush never clears them.
  - `sq_empty` and `no_commited_ops_pending` include the register.
- Undefined: `mem_entry` is driven combinationally from the head slot, with the latency described above.

## Test plan
- Reset: after `rst` is held for 2 cycles → `sq_empty`=1, `full`=0, `mem_valid`=0, `no_commited_ops_pending`=1.
- Push IDs 3,4,5; retire 3 in cycle N → `mem_valid`=1 at N+1 with ID 3's payload. Hold `mem_ready`=0 for 3 cycles → payload stable. Assert `mem_ready` → 4 is not issued until it is retired.
- DEPTH=4: fill the queue → `full`=1. Pop and push in the same cycle over 10 iterations → pointers wrap and data order is preserved.
- Push 1,2,3; retire 1 and assert `flush` in the same cycle → 1 issues, 2 and 3 are dropped, and `sq_empty`=1 after the pop.
- Push ID 7 with `retire_valid`=1, `retire_id`=7 in the same cycle → entry is committed at insertion and `mem_valid` asserts next cycle.
- Retire ID 9, which is not present → no state change.
